sram_bank_arbiter: RTL and testbench

- Round-robin arbiter sharing one single-port tc_sram bank (1 access/cycle, fixed read latency) between NumReq requesters.
- Requester side is a req/gnt/rvalid interface.
- Tracks in-flight reads in a latency-matched pipeline and routes each read response back to its issuer.
- Sits between core/DMA ports and each SRAM bank of the tile.

---
 rtl/sram_bank_arbiter.sv | 168 ++++++++++++++++
 tb/tb_sram_bank_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM bank between requesters.
// In-flight reads ride a latency-matched pipeline back to their issuer.
module sram_bank_arbiter #(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned NumWords  = 256,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned Latency   = 1,
    parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
    parameter int unsigned IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq-1:0]             we_i,
    input  logic [NumReq*AddrWidth-1:0]   addr_i,
    input  logic [NumReq*DataWidth-1:0]   wdata_i,
    input  logic [NumReq*BeWidth-1:0]     be_i,
    output logic [NumReq-1:0]             gnt_o,
    output logic [NumReq-1:0]             rvalid_o,
    output logic [DataWidth-1:0]          rdata_o,
    output logic                          err_o,
    output logic                          sram_req_o,
    output logic                          sram_we_o,
    output logic [AddrWidth-1:0]          sram_addr_o,
    output logic [DataWidth-1:0]          sram_wdata_o,
    output logic [BeWidth-1:0]            sram_be_o,
    input  logic [DataWidth-1:0]          sram_rdata_i
);

    if (NumReq < 1 || NumReq > 16) begin : g_bad_numreq
        $error("NumReq must be in 1..16");
    end
    if (Latency < 1 || Latency > 4) begin : g_bad_latency
        $error("Latency must be in 1..4");
    end

    // Round-robin pointer: index holding highest priority this cycle.
    logic [IdxWidth-1:0] rr_q, rr_d;

    // Arbitration result.
    logic                win_valid;
    logic [IdxWidth-1:0] win_idx;

    // Fields of the winning request.
    logic                 w_we;
    logic [AddrWidth-1:0] w_addr;
    logic [DataWidth-1:0] w_wdata;
    logic [BeWidth-1:0]   w_be;
    logic                 w_in_range;

    // Response pipeline, one entry per cycle of bank latency.
    logic [Latency-1:0]  vld_q, vld_d;
    logic [Latency-1:0]  err_q, err_d;
    logic [IdxWidth-1:0] idx_q [Latency];
    logic [IdxWidth-1:0] idx_d [Latency];

    // Scan requesters starting at rr_q, first asserted request wins.
    always_comb begin
        logic [IdxWidth-1:0] cand;
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = IdxWidth'((32'(rr_q) + i) % NumReq);
            if (!win_valid && req_i[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Priority moves just past the accepted requester, holds when idle.
    always_comb begin
        rr_d = rr_q;
        if (win_valid) begin
            rr_d = IdxWidth'((32'(win_idx) + 1) % NumReq);
        end
    end

    // Select the winner's command fields.
    always_comb begin
        w_we    = we_i[win_idx];
        w_addr  = addr_i[win_idx * AddrWidth +: AddrWidth];
        w_wdata = wdata_i[win_idx * DataWidth +: DataWidth];
        w_be    = be_i[win_idx * BeWidth +: BeWidth];
    end

    // A power-of-two bank cannot be addressed out of range.
    if (NumWords == (1 << AddrWidth)) begin : g_full_range
        assign w_in_range = 1'b1;
    end else begin : g_part_range
        assign w_in_range = (32'(w_addr) < NumWords);
    end

    // One-hot grant to the winner.
    always_comb begin
        gnt_o = '0;
        if (win_valid) begin
            gnt_o[win_idx] = 1'b1;
        end
    end

    // Bank drive: command muxed from winner, zeros when idle.
    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (win_valid) begin
            sram_req_o   = w_in_range;
            sram_we_o    = w_we;
            sram_addr_o  = w_addr;
            sram_wdata_o = w_wdata;
            sram_be_o    = w_be;
        end
    end

    // Stage 0 captures accepted reads; later stages shift every cycle.
    always_comb begin
        vld_d    = '0;
        err_d    = '0;
        vld_d[0] = win_valid && !w_we;
        err_d[0] = !w_in_range;
        idx_d[0] = win_idx;
        for (int unsigned s = 1; s < Latency; s++) begin
            vld_d[s] = vld_q[s-1];
            err_d[s] = err_q[s-1];
            idx_d[s] = idx_q[s-1];
        end
    end

    // Pointer and pipeline registers; reset drops in-flight reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q  <= '0;
            vld_q <= '0;
            err_q <= '0;
            for (int unsigned s = 0; s < Latency; s++) begin
                idx_q[s] <= '0;
            end
        end else begin
            rr_q  <= rr_d;
            vld_q <= vld_d;
            err_q <= err_d;
            for (int unsigned s = 0; s < Latency; s++) begin
                idx_q[s] <= idx_d[s];
            end
        end
    end

    // Route the last stage back to its issuer; errored reads return 0.
    always_comb begin
        rvalid_o = '0;
        err_o    = 1'b0;
        rdata_o  = '0;
        if (vld_q[Latency-1]) begin
            rvalid_o[idx_q[Latency-1]] = 1'b1;
            err_o = err_q[Latency-1];
            if (!err_q[Latency-1]) begin
                rdata_o = sram_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Bench for sram_bank_arbiter: two instances (full and partial bank)
// driven in lockstep and checked against a round-robin/scoreboard model.
module tb_sram_bank_arbiter;

    localparam int NR    = 4;
    localparam int DW    = 32;
    localparam int BEW   = 4;
    localparam int AW    = 8;
    localparam int NW_A  = 256;
    localparam int LAT_A = 1;
    localparam int NW_B  = 200;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NR-1:0]     req, we;
    logic [NR*AW-1:0]  addr;
    logic [NR*DW-1:0]  wdata;
    logic [NR*BEW-1:0] be;

    logic [NR-1:0]  gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [DW-1:0]  rdata_a, rdata_b, swdata_a, swdata_b, srdata_a, srdata_b;
    logic           err_a, err_b, sreq_a, sreq_b, swe_a, swe_b;
    logic [AW-1:0]  saddr_a, saddr_b;
    logic [BEW-1:0] sbe_a, sbe_b;

    sram_bank_arbiter #(
        .NumReq(NR), .NumWords(NW_A), .DataWidth(DW),
        .ByteWidth(8), .Latency(LAT_A)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be),
        .gnt_o(gnt_a), .rvalid_o(rvalid_a),
        .rdata_o(rdata_a), .err_o(err_a),
        .sram_req_o(sreq_a), .sram_we_o(swe_a),
        .sram_addr_o(saddr_a), .sram_wdata_o(swdata_a),
        .sram_be_o(sbe_a), .sram_rdata_i(srdata_a)
    );

    sram_bank_arbiter #(
        .NumReq(NR), .NumWords(NW_B), .DataWidth(DW),
        .ByteWidth(8), .Latency(LAT_B)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be),
        .gnt_o(gnt_b), .rvalid_o(rvalid_b),
        .rdata_o(rdata_b), .err_o(err_b),
        .sram_req_o(sreq_b), .sram_we_o(swe_b),
        .sram_addr_o(saddr_b), .sram_wdata_o(swdata_b),
        .sram_be_o(sbe_b), .sram_rdata_i(srdata_b)
    );

    // Behavioural banks with fixed read latency; idle slots carry junk.
    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];
    logic [DW-1:0] pipe_a [LAT_A];
    logic [DW-1:0] pipe_b [LAT_B];

    always @(posedge clk) begin
        if (sreq_a && swe_a)
            for (int b = 0; b < BEW; b++)
                if (sbe_a[b]) mem_a[saddr_a][b*8 +: 8] <= swdata_a[b*8 +: 8];
        pipe_a[0] <= (sreq_a && !swe_a) ? mem_a[saddr_a] : DW'($urandom);
        for (int s = 1; s < LAT_A; s++) pipe_a[s] <= pipe_a[s-1];
    end

    always @(posedge clk) begin
        if (sreq_b && swe_b)
            for (int b = 0; b < BEW; b++)
                if (sbe_b[b]) mem_b[saddr_b][b*8 +: 8] <= swdata_b[b*8 +: 8];
        pipe_b[0] <= (sreq_b && !swe_b) ? mem_b[saddr_b] : DW'($urandom);
        for (int s = 1; s < LAT_B; s++) pipe_b[s] <= pipe_b[s-1];
    end

    assign srdata_a = pipe_a[LAT_A-1];
    assign srdata_b = pipe_b[LAT_B-1];

    // Reference model state.
    int n_chk = 0;
    int n_err = 0;
    int rr;
    int cyc;
    bit             pend    [NR];
    bit             p_we    [NR];
    logic [AW-1:0]  p_addr  [NR];
    logic [DW-1:0]  p_wdata [NR];
    logic [BEW-1:0] p_be    [NR];
    int             waitc   [NR];
    logic [DW-1:0]  ref_a [256];
    logic [DW-1:0]  ref_b [256];

    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] data;
        bit            err;
    } rsp_t;

    rsp_t q_a[$];
    rsp_t q_b[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o,
                                            input logic [DW-1:0] w,
                                            input logic [BEW-1:0] b);
        logic [DW-1:0] r = o;
        for (int i = 0; i < BEW; i++)
            if (b[i]) r[i*8 +: 8] = w[i*8 +: 8];
        return r;
    endfunction

    task automatic set_req(input int p, input bit w, input int a,
                           input logic [DW-1:0] d, input logic [BEW-1:0] e);
        pend[p]    = 1'b1;
        p_we[p]    = w;
        p_addr[p]  = AW'(a);
        p_wdata[p] = d;
        p_be[p]    = e;
    endtask

    task automatic rand_req(input int p);
        int a;
        a = ($urandom % 2 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255);
        set_req(p, ($urandom % 3 == 0), a, DW'($urandom),
                BEW'($urandom_range(0, 15)));
    endtask

    task automatic drive();
        for (int p = 0; p < NR; p++) begin
            req[p]              = pend[p];
            we[p]               = pend[p] ? p_we[p] : 1'($urandom);
            addr[p*AW +: AW]    = pend[p] ? p_addr[p] : AW'($urandom);
            wdata[p*DW +: DW]   = pend[p] ? p_wdata[p] : DW'($urandom);
            be[p*BEW +: BEW]    = pend[p] ? p_be[p] : BEW'($urandom);
        end
    endtask

    task automatic check_rsp(input string tag, input bit h, input rsp_t r,
                             input logic [NR-1:0] rv, input logic [DW-1:0] rd,
                             input logic e);
        logic [NR-1:0] erv;
        erv = h ? NR'(1 << r.idx) : '0;
        chk({"rvalid_", tag}, rv, erv);
        chk({"err_", tag}, e, h && r.err);
        chk({"rdata_", tag}, rd, (h && !r.err) ? r.data : '0);
    endtask

    task automatic step();
        int k;
        int j;
        int a;
        bit inb;
        bit h;
        rsp_t r;
        rsp_t z;
        logic [NR-1:0] eg;
        z = '{due: 0, idx: 0, data: '0, err: 1'b0};
        drive();
        k = -1;
        for (int i = 0; i < NR; i++) begin
            j = (rr + i) % NR;
            if (k < 0 && pend[j]) k = j;
        end
        @(negedge clk);
        eg = (k >= 0) ? NR'(1 << k) : '0;
        chk("gnt_a", gnt_a, eg);
        chk("gnt_b", gnt_b, eg);
        a = (k >= 0) ? int'(p_addr[k]) : 0;
        inb = (k >= 0) && (a < NW_B);
        chk("sreq_a", sreq_a, k >= 0);
        chk("sreq_b", sreq_b, inb);
        if (k >= 0) begin
            chk("swe_a", swe_a, p_we[k]);
            chk("saddr_a", saddr_a, p_addr[k]);
            chk("swdata_a", swdata_a, p_wdata[k]);
            chk("sbe_a", sbe_a, p_be[k]);
            chk("saddr_b", saddr_b, p_addr[k]);
        end else begin
            chk("sidle_a", {swe_a, saddr_a, swdata_a, sbe_a}, '0);
        end
        h = (q_a.size() > 0) && (q_a[0].due == cyc);
        r = h ? q_a.pop_front() : z;
        check_rsp("a", h, r, rvalid_a, rdata_a, err_a);
        h = (q_b.size() > 0) && (q_b[0].due == cyc);
        r = h ? q_b.pop_front() : z;
        check_rsp("b", h, r, rvalid_b, rdata_b, err_b);
        @(posedge clk);
        if (k >= 0) begin
            chk("fair", waitc[k] < NR, 1);
            rr = (k + 1) % NR;
            if (p_we[k]) begin
                ref_a[a] = merge(ref_a[a], p_wdata[k], p_be[k]);
                if (inb) ref_b[a] = merge(ref_b[a], p_wdata[k], p_be[k]);
            end else begin
                q_a.push_back('{due: cyc + LAT_A, idx: k,
                                data: ref_a[a], err: 1'b0});
                q_b.push_back('{due: cyc + LAT_B, idx: k,
                                data: inb ? ref_b[a] : '0, err: !inb});
            end
            pend[k]  = 1'b0;
            waitc[k] = 0;
        end
        for (int p = 0; p < NR; p++)
            if (pend[p]) waitc[p]++;
        cyc++;
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"}, {gnt_a, gnt_b}, '0);
        chk({tag, "_rvalid"}, {rvalid_a, rvalid_b}, '0);
        chk({tag, "_err"}, {err_a, err_b}, '0);
        chk({tag, "_rdata"}, {rdata_a, rdata_b}, '0);
        chk({tag, "_sreq"}, {sreq_a, sreq_b}, '0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
            mem_b[i] = mem_a[i];
            ref_a[i] = mem_a[i];
            ref_b[i] = mem_a[i];
        end
        rr  = 0;
        cyc = 0;
        for (int p = 0; p < NR; p++) begin
            pend[p]  = 1'b0;
            waitc[p] = 0;
        end
        rst_n = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst_n = 1'b1;

        // All four ports read at once: grants rotate 0,1,2,3.
        for (int p = 0; p < NR; p++) set_req(p, 1'b0, 3 * p + 1, '0, '0);
        repeat (NR + LAT_B) step();

        // Write then read back through a different port.
        set_req(2, 1'b1, 5, 32'hDEADBEEF, 4'hF);
        step();
        set_req(0, 1'b0, 5, '0, '0);
        repeat (LAT_B + 1) step();

        // Out-of-range for the 200-word bank, in range for the full one.
        set_req(1, 1'b0, 210, '0, '0);
        repeat (LAT_B + 1) step();
        set_req(1, 1'b1, 230, 32'h12345678, 4'hF);
        step();
        set_req(3, 1'b0, 230, '0, '0);
        repeat (LAT_B + 1) step();

        // Port 3 continuous while ports 0 and 1 alternate.
        repeat (24) begin
            if (!pend[3]) rand_req(3);
            if (!pend[cyc % 2]) rand_req(cyc % 2);
            step();
        end
        repeat (LAT_B + 2) step();

        // Reset with reads in flight: nothing must come back.
        set_req(2, 1'b0, 9, '0, '0);
        step();
        set_req(1, 1'b0, 11, '0, '0);
        step();
        rst_n = 1'b0;
        for (int p = 0; p < NR; p++) begin
            pend[p]  = 1'b0;
            waitc[p] = 0;
        end
        drive();
        #1;
        chk_quiet("midrst");
        q_a.delete();
        q_b.delete();
        rr = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_quiet("midrst_hold");
        rst_n = 1'b1;
        cyc += 2;
        repeat (LAT_B + 1) step();
        for (int p = NR - 1; p >= 0; p--) set_req(p, 1'b0, 40 + p, '0, '0);
        repeat (NR + LAT_B) step();

        // Randomized traffic.
        repeat (800) begin
            for (int p = 0; p < NR; p++)
                if (!pend[p] && ($urandom % 2 == 0)) rand_req(p);
            step();
        end
        repeat (NR + LAT_B + 2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
